// File: rtl/regfile_mp.sv
// Multi-port register file with fixed-priority writes, optional zero register and busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module regfile_mp #(
    parameter int W_DATA   = 32,
    parameter int N_REGS   = 32,
    parameter int N_RD     = 2,
    parameter int N_WR     = 1,
    parameter int ZERO_REG = 1,
    localparam int W_ADDR  = $clog2(N_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_WR-1:0]          wren,
    input  logic [N_WR*W_ADDR-1:0]   wa,
    input  logic [N_WR*W_DATA-1:0]   wd,
    input  logic [N_RD*W_ADDR-1:0]   ra,
    output logic [N_RD*W_DATA-1:0]   rd,
    output logic [N_RD-1:0]          rd_busy,
    input  logic                     rsv_en,
    input  logic [W_ADDR-1:0]        rsv_a,
    output logic                     rsv_ready,
    output logic [W_ADDR:0]          busy_cnt
);

    genvar gi;

    logic [W_DATA-1:0] rf_reg [N_REGS];
    logic [N_REGS-1:0] sb_reg;
    logic [N_REGS-1:0] sb_next;
    logic [W_ADDR:0]   busy_cnt_reg;
    logic [W_ADDR:0]   busy_cnt_next;

    logic [W_ADDR-1:0] wa_arr [N_WR];
    logic [W_DATA-1:0] wd_arr [N_WR];
    logic [N_WR-1:0]   wr_ok;

    logic rsv_zero;
    logic rsv_set;

    // Unpack write ports; writes to a hardwired zero register are discarded here.
    for (gi = 0; gi < N_WR; gi++) begin : g_wr
        assign wa_arr[gi] = wa[gi*W_ADDR +: W_ADDR];
        assign wd_arr[gi] = wd[gi*W_DATA +: W_DATA];
        assign wr_ok[gi]  = wren[gi] && !((ZERO_REG != 0) && (wa_arr[gi] == '0));
    end

    assign rsv_zero  = (ZERO_REG != 0) && (rsv_a == '0);
    assign rsv_ready = rsv_zero || !sb_reg[rsv_a];
    assign rsv_set   = rsv_en && rsv_ready && !rsv_zero;

    // Later ports are applied last, so the highest-numbered port wins a collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < N_REGS; r++) begin
                rf_reg[r] <= '0;
            end
        end else begin
            for (int k = 0; k < N_WR; k++) begin
                if (wr_ok[k]) begin
                    rf_reg[wa_arr[k]] <= wd_arr[k];
                end
            end
        end
    end

    // Writeback clears busy first; a same-cycle reservation then re-marks it (new producer wins).
    always_comb begin
        sb_next = sb_reg;
        for (int k = 0; k < N_WR; k++) begin
            if (wr_ok[k]) begin
                sb_next[wa_arr[k]] = 1'b0;
            end
        end
        if (rsv_set) begin
            sb_next[rsv_a] = 1'b1;
        end
    end

    always_comb begin
        busy_cnt_next = '0;
        for (int r = 0; r < N_REGS; r++) begin
            busy_cnt_next = busy_cnt_next + (W_ADDR+1)'(sb_next[r]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_reg       <= '0;
            busy_cnt_reg <= '0;
        end else begin
            sb_reg       <= sb_next;
            busy_cnt_reg <= busy_cnt_next;
        end
    end

    assign busy_cnt = busy_cnt_reg;

    for (gi = 0; gi < N_RD; gi++) begin : g_rd
        logic [W_ADDR-1:0] addr;
        logic [W_DATA-1:0] data;
        logic              busy;

        assign addr = ra[gi*W_ADDR +: W_ADDR];

        always_comb begin
            data = rf_reg[addr];
            busy = sb_reg[addr];
            if ((ZERO_REG != 0) && (addr == '0)) begin
                data = '0;
                busy = 1'b0;
            end
`ifdef REGFILE_BYPASS_EN
            // Ascending scan leaves the highest-numbered matching port in place.
            for (int k = 0; k < N_WR; k++) begin
                if (wr_ok[k] && (wa_arr[k] == addr)) begin
                    data = wd_arr[k];
                    busy = 1'b0;
                end
            end
`endif
        end

        assign rd[gi*W_DATA +: W_DATA] = data;
        assign rd_busy[gi]             = busy;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp (2 read, 2 write ports) against an array-based reference model.
module tb_regfile_mp;

    localparam int WD = 32;
    localparam int WA = 5;
    localparam int NR = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        wren;
    logic [2*WA-1:0]   wa;
    logic [2*WD-1:0]   wd;
    logic [2*WA-1:0]   ra;
    logic [2*WD-1:0]   rd;
    logic [1:0]        rd_busy;
    logic              rsv_en;
    logic [WA-1:0]     rsv_a;
    logic              rsv_ready;
    logic [WA:0]       busy_cnt;

    regfile_mp #(.W_DATA(WD), .N_REGS(NR), .N_RD(2), .N_WR(2), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .wren(wren), .wa(wa), .wd(wd), .ra(ra), .rd(rd),
        .rd_busy(rd_busy), .rsv_en(rsv_en), .rsv_a(rsv_a), .rsv_ready(rsv_ready),
        .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          kind;   // 0 rd, 1 rd_busy, 2 rsv_ready, 3 busy_cnt
        int          port;
        logic [31:0] exp;
    } exp_t;

    exp_t        sbq[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_err = 0;
    logic [31:0] m_rf [NR];
    bit          m_busy [NR];
    bit          model_known = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every cycle, compare all expectations tagged with the current cycle.
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].cyc == cyc) begin
            exp_t e;
            logic [31:0] act;
            string nm;
            e = sbq.pop_front();
            case (e.kind)
                0: begin act = rd[e.port*WD +: WD];     nm = $sformatf("rd%0d", e.port); end
                1: begin act = {31'b0, rd_busy[e.port]}; nm = $sformatf("rd_busy%0d", e.port); end
                2: begin act = {31'b0, rsv_ready};       nm = "rsv_ready"; end
                default: begin act = {26'b0, busy_cnt};  nm = "busy_cnt"; end
            endcase
            n_checks++;
            if (act !== e.exp) begin
                n_err++;
                $display("FAIL %s cyc=%0d actual=%h required=%h", nm, e.cyc, act, e.exp);
            end
        end
    end

    function automatic int model_count();
        int c = 0;
        foreach (m_busy[r]) c += m_busy[r];
        return c;
    endfunction

    // Drive one cycle, queue the expected combinational outputs, advance the model across the edge.
    task automatic step(input logic r, input logic [1:0] we,
                        input logic [WA-1:0] a0, input logic [WA-1:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic [WA-1:0] q0, input logic [WA-1:0] q1,
                        input logic re, input logic [WA-1:0] ar);
        logic [WA-1:0] wadr [2];
        logic [31:0]   wdat [2];
        logic [WA-1:0] radr [2];
        bit            ready;
        rst = r; wren = we; wa = {a1, a0}; wd = {d1, d0}; ra = {q1, q0};
        rsv_en = re; rsv_a = ar;
        wadr[0] = a0; wadr[1] = a1; wdat[0] = d0; wdat[1] = d1;
        radr[0] = q0; radr[1] = q1;
        ready = (ar == 0) || !m_busy[ar];
        if (model_known) begin
            for (int p = 0; p < 2; p++) begin
                logic [31:0] v;
                bit b;
                v = (radr[p] == 0) ? 32'h0 : m_rf[radr[p]];
                b = m_busy[radr[p]];
`ifdef REGFILE_BYPASS_EN
                for (int k = 0; k < 2; k++)
                    if (we[k] && wadr[k] == radr[p] && radr[p] != 0) begin
                        v = wdat[k];
                        b = 0;
                    end
`endif
                sbq.push_back('{cyc, 0, p, v});
                sbq.push_back('{cyc, 1, p, {31'b0, b}});
            end
            sbq.push_back('{cyc, 2, 0, {31'b0, ready}});
            sbq.push_back('{cyc, 3, 0, model_count()});
        end
        $display("cyc=%0d rst=%0b wren=%b wa=%0d/%0d wd=%h/%h ra=%0d/%0d rsv=%0b@%0d",
                 cyc, r, we, a0, a1, d0, d1, q0, q1, re, ar);
        if (r) begin
            foreach (m_rf[i]) begin m_rf[i] = 0; m_busy[i] = 0; end
            model_known = 1;
        end else begin
            for (int k = 0; k < 2; k++)
                if (we[k] && wadr[k] != 0) begin
                    m_rf[wadr[k]] = wdat[k];
                    m_busy[wadr[k]] = 0;
                end
            if (re && ready && ar != 0) m_busy[ar] = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_read(input logic [WA-1:0] q0, input logic [WA-1:0] q1);
        step(0, 2'b00, 0, 0, 0, 0, q0, q1, 0, q1);
    endtask

    initial begin
        rst = 1; wren = 0; wa = 0; wd = 0; ra = 0; rsv_en = 0; rsv_a = 0;
        @(posedge clk); #1;
        step(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        // Post-reset sweep of every register.
        for (int r = 0; r < NR; r += 2) idle_read(WA'(r), WA'(r + 1));
        // r5 write then read on both ports; r0 write ignored.
        step(0, 2'b01, 5, 0, 32'hDEADBEEF, 0, 5, 5, 0, 0);
        step(0, 2'b01, 0, 0, 32'h1234, 0, 5, 5, 0, 0);
        idle_read(0, 5);
        // Both ports hit r7: port 1 wins.
        step(0, 2'b11, 7, 7, 32'h1111, 32'h2222, 7, 0, 0, 0);
        idle_read(7, 7);
        // Reserve r9, retry is dropped, writeback clears.
        step(0, 2'b00, 0, 0, 0, 0, 9, 9, 1, 9);
        step(0, 2'b00, 0, 0, 0, 0, 9, 9, 1, 9);
        step(0, 2'b01, 9, 0, 32'h55, 0, 9, 9, 0, 9);
        idle_read(9, 9);
        // Reserve and write r3 together, then reset.
        step(0, 2'b01, 3, 0, 32'hAA, 0, 3, 3, 1, 3);
        step(1, 2'b00, 0, 0, 0, 0, 3, 3, 0, 3);
        idle_read(3, 3);
        // Read r4 in the cycle it is written.
        step(0, 2'b01, 4, 0, 32'h11, 0, 4, 4, 0, 0);
        step(0, 2'b10, 0, 4, 0, 32'h77, 4, 4, 0, 0);
        idle_read(4, 4);
        // Reserving r0 never marks it busy.
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0);
        idle_read(0, 0);
        // Randomized traffic over a narrow address range to force collisions.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) == 0), 2'($urandom_range(0, 3)),
                 WA'($urandom_range(0, 11)), WA'($urandom_range(0, 11)),
                 $urandom, $urandom,
                 WA'($urandom_range(0, 11)), WA'($urandom_range(0, 11)),
                 1'($urandom_range(0, 1)), WA'($urandom_range(0, 11)));
        end
        idle_read(0, 0);
        // Bounded drain: the monitor must have consumed every queued expectation.
        for (int t = 0; t < 4 && sbq.size() > 0; t++) @(negedge clk);
        n_checks++;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL drain actual=%0d required=0 pending", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the CPU and coprocessor datapaths, replacing the fixed 2-read/1-write file. It supports N read ports, M write ports with fixed priority, an optional hardwired zero register, and a per-register busy scoreboard that issue logic uses to reserve destinations and detect RAW hazards. An optional write-to-read bypass is compiled in by macro.

## Interface
- `W_DATA`, 32: register width in bits.
- `N_REGS`, 32: number of registers; power of two, ≥ 2.
- `W_ADDR`, `$clog2(N_REGS)`: address width; derived, not overridden.
- `N_RD`, 2: read ports, 1..4.
- `N_WR`, 1: write ports, 1..2.
- `ZERO_REG`, 1: 1 = register 0 reads 0, ignores writes and is never busy.

- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wren`  in  N_WR  per-port write enable.
- `wa`  in  N_WR*W_ADDR  write addresses, port k at bits [k*W_ADDR +: W_ADDR].
- `wd`  in  N_WR*W_DATA  write data, same packing.
- `ra`  in  N_RD*W_ADDR  read addresses.
- `rd`  out  N_RD*W_DATA  read data, combinational.
- `rd_busy`  out  N_RD  busy bit of each addressed register, combinational.
- `rsv_en`  in  1  reserve-destination request.
- `rsv_a`  in  W_ADDR  register to reserve.
- `rsv_ready`  out  1  reservation will be accepted this cycle.
- `busy_cnt`  out  W_ADDR+1  number of registers currently busy.

## Operation
- Storage: N_REGS × W_DATA array `rf`, plus a busy vector `sb[N_REGS-1:0]` and the `busy_cnt` counter.
- Write: at each rising edge, for each k with `wren[k]`, `rf[wa_k] <= wd_k`. If both ports target the same address, port 1 wins. With ZERO_REG=1, writes to address 0 are dropped.
- Write clears the target's busy bit: `sb[wa_k] <= 0` for every enabled write.
- Read: `rd_i = rf[ra_i]`, or 0 when ZERO_REG=1 and `ra_i == 0`. `rd_busy_i = sb[ra_i]`.
- Reserve handshake: `rsv_ready = !sb[rsv_a]`, and it is 1 for address 0 when ZERO_REG=1. A reservation is accepted when `rsv_en && rsv_ready`, which sets `sb[rsv_a] <= 1`.
  - Reserving address 0 with ZERO_REG=1 is accepted but has no effect.
  - Requests that are not accepted are dropped; the issuer must hold `rsv_en` and retry.
- Simultaneous accepted reserve and write to the same register: the write updates `rf`, and the busy bit ends at 1 (the new producer wins).
- `busy_cnt` equals the population count of `sb` after the update: +1 per newly set bit, −1 per cleared bit that was set. Writes to non-busy registers do not change it.

## Timing
- Reset, when `rst` is high at an edge:
  - all `rf` entries and all `sb` bits are cleared; `busy_cnt` = 0;
  - the following cycle, `rd` = 0, `rd_busy` = 0 and `rsv_ready` = 1.
  - `rst` overrides writes and reservations issued in the same cycle.
- Write-to-read latency: the new value appears on `rd` the cycle after `wren` (without the bypass macro).
- Reserve-to-busy latency: `rd_busy` and `rsv_ready` reflect a reservation the cycle after it is accepted.
- Writeback clears busy in the same edge that stores the data; there is no extra cycle.
- No multicycle paths. All outputs are combinational from state and inputs, so downstream logic must register them.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - when a write is enabled this cycle to `ra_i` (excluding address 0 with ZERO_REG=1), `rd_i` returns that `wd` and `rd_busy_i` returns 0, both combinationally;
  - the highest-numbered matching write port supplies the data.
- `REGFILE_BYPASS_EN` undefined:
  - `rd`/`rd_busy` reflect pre-edge state only; a same-cycle write is visible the next cycle.

## Test plan
- Reset then read all registers: `rd` = 0, `rd_busy` = 0, `busy_cnt` = 0, `rsv_ready` = 1.
- Write `0xDEADBEEF` to r5, read r5 on both ports next cycle -> `0xDEADBEEF`. Write `0x1234` to r0 -> r0 still reads 0.
- N_WR=2, both ports write r7 (`0x1111`, `0x2222`) in the same cycle -> r7 reads `0x2222`.
- Reserve r9 -> `rd_busy` = 1, `busy_cnt` = 1, `rsv_ready` = 0 for r9. Reserve r9 again -> dropped, count stays 1. Write r9 = `0x55` -> busy 0, count 0, data `0x55`.
- Reserve r3 and write r3 = `0xAA` in the same cycle -> r3 reads `0xAA`, busy = 1, count = 1. Assert `rst` the next cycle -> count 0, r3 reads 0.
- Write r4 = `0x77` while reading r4 in the same cycle:
  - with `REGFILE_BYPASS_EN`, `rd` = `0x77` that cycle;
  - without it, `rd` shows the old value, then `0x77` next cycle.
